// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared limits, slice-width helper and stage record for pipe_adder.
package pipe_adder_pkg;

    localparam int PA_MIN_WIDTH = 2;
    localparam int PA_MAX_WIDTH = 64;

    // Fields are sized for the widest legal build; only the low WIDTH bits carry data.
    typedef struct packed {
        logic                    valid;
        logic                    carry;
        logic [PA_MAX_WIDTH-1:0] sum;
        logic [PA_MAX_WIDTH-1:0] a;
        logic [PA_MAX_WIDTH-1:0] b;
    } stage_t;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result valid-ready bundle for pipe_adder.
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             CO;

    modport slave (
        input  IN_VALID, A, B, CI, OUT_READY,
        output IN_READY, OUT_VALID, SUM, CO
    );

    modport master (
        output IN_VALID, A, B, CI, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, CO
    );
endinterface

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: adds slice K plus incoming carry and holds the result in a valid/ready register.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int K      = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t up,
    input  logic   down_ready,
    output logic   ready,
    output stage_t stg
);
    localparam int W = slice_w(WIDTH, STAGES);

    stage_t     stg_q, stg_d;
    logic [W:0] add;

    assign ready = !stg_q.valid || down_ready;
    assign stg   = stg_q;

    // Data fields only move with a valid beat; an empty load just clears valid.
    always_comb begin
        add   = {1'b0, up.a[K*W +: W]} + {1'b0, up.b[K*W +: W]} + {{W{1'b0}}, up.carry};
        stg_d = stg_q;
        if (ready) begin
            stg_d.valid = up.valid;
            if (up.valid) begin
                stg_d.carry          = add[W];
                stg_d.sum            = up.sum;
                stg_d.sum[K*W +: W]  = add[W-1:0];
                stg_d.a              = up.a;
                stg_d.b              = up.b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_d;
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep slice-pipelined adder with valid/ready flow control.
// Define PIPE_ADDER_SAT_EN to force SUM to all ones whenever CO is set.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic         CLK,
    input logic         RSTB,
    pipe_adder_if.slave bus
);
    stage_t in_rec;
    stage_t stg [STAGES];
    logic   rdy [STAGES+1];
    logic   run_q, run_d;

    if (WIDTH < PA_MIN_WIDTH || WIDTH > PA_MAX_WIDTH || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: illegal WIDTH/STAGES combination");
    end

    // Holds IN_READY low until the first edge after reset release.
    assign run_d = 1'b1;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) run_q <= 1'b0;
        else       run_q <= run_d;
    end

    always_comb begin
        in_rec              = '0;
        in_rec.valid        = bus.IN_VALID && run_q;
        in_rec.carry        = bus.CI;
        in_rec.a[WIDTH-1:0] = bus.A;
        in_rec.b[WIDTH-1:0] = bus.B;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t up;
        if (k == 0) begin : g_first
            assign up = in_rec;
        end else begin : g_next
            assign up = stg[k-1];
        end
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .K     (k)
        ) u_stage (
            .clk       (CLK),
            .rst_n     (RSTB),
            .up        (up),
            .down_ready(rdy[k+1]),
            .ready     (rdy[k]),
            .stg       (stg[k])
        );
    end

    assign rdy[STAGES]   = bus.OUT_READY;
    assign bus.IN_READY  = rdy[0] && run_q;
    assign bus.OUT_VALID = stg[STAGES-1].valid;
    assign bus.CO        = stg[STAGES-1].carry;
`ifdef PIPE_ADDER_SAT_EN
    assign bus.SUM = stg[STAGES-1].carry ? {WIDTH{1'b1}} : stg[STAGES-1].sum[WIDTH-1:0];
`else
    assign bus.SUM = stg[STAGES-1].sum[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (WIDTH=16, STAGES=4).
module tb_pipe_adder;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        int          cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rstb;
    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic  acc;
    logic  stall_prev = 1'b0;
    logic  lat_chk = 1'b0;
    logic [15:0] a_v = '0, b_v = '0;
    logic  ci_v = 1'b0, iv = 1'b0, or_v = 1'b0;

    pipe_adder_if #(.WIDTH(16)) bus ();

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .CLK (clk),
        .RSTB(rstb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        exp_t e;
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        e.co = s[16];
`ifdef PIPE_ADDER_SAT_EN
        e.sum = s[16] ? 16'hFFFF : s[15:0];
`else
        e.sum = s[15:0];
`endif
        e.cyc = cyc;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        bus.IN_VALID  = iv;
        bus.A         = a_v;
        bus.B         = b_v;
        bus.CI        = ci_v;
        bus.OUT_READY = or_v;
        #1;
        acc = bus.IN_VALID && bus.IN_READY;
        if (acc) q.push_back(model(a_v, b_v, ci_v));
        if (stall_prev) check("hold_valid", bus.OUT_VALID, 1);
        if (bus.OUT_VALID && q.size() == 0) check("spurious_valid", bus.OUT_VALID, 0);
        if (bus.OUT_VALID && q.size() != 0) begin
            check("sum", bus.SUM, q[0].sum);
            check("co", bus.CO, q[0].co);
            if (bus.OUT_READY) begin
                e = q.pop_front();
                if (lat_chk) check("latency", cyc - e.cyc, 4);
            end
        end
        stall_prev = bus.OUT_VALID && !bus.OUT_READY;
        cyc++;
    endtask

    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int g = 0;
        a_v = a; b_v = b; ci_v = ci; iv = 1'b1; or_v = 1'b1; lat_chk = 1'b1;
        do begin tick(); g++; end while (!acc && g < 20);
        iv = 1'b0;
        while (q.size() != 0 && g < 40) begin tick(); g++; end
        check("one_drained", q.size(), 0);
        lat_chk = 1'b0;
    endtask

    task automatic run_beats(input int n, input int pv, input int pr, input logic lat);
        int   sent = 0;
        int   g = 0;
        logic have = 1'b0;
        lat_chk = lat;
        while ((sent < n || q.size() != 0) && g < 20000) begin
            if (!have && sent < n) begin
                a_v = 16'($urandom); b_v = 16'($urandom); ci_v = 1'($urandom); have = 1'b1;
            end
            iv   = have && ($urandom_range(99) < pv);
            or_v = $urandom_range(99) < pr;
            tick();
            if (acc) begin have = 1'b0; sent++; end
            g++;
        end
        iv = 1'b0;
        check("beats_sent", sent, n);
        check("beats_drained", q.size(), 0);
        lat_chk = 1'b0;
    endtask

    initial begin
        int idx;
        int g;
        bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.CI = 1'b0; bus.OUT_READY = 1'b0;
        rstb = 1'b1;
        #1 rstb = 1'b0;
        #1;
        check("rst_out_valid", bus.OUT_VALID, 0);
        check("rst_in_ready", bus.IN_READY, 0);
        check("rst_sum", bus.SUM, 0);
        check("rst_co", bus.CO, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstb = 1'b1;
        #1 check("rdy_before_edge", bus.IN_READY, 0);
        tick();
        check("rdy_after_edge", bus.IN_READY, 1);

        send_one(16'h1234, 16'h0FFF, 1'b1);
        send_one(16'hFFFF, 16'h0000, 1'b1);
        send_one(16'hFFFF, 16'h0001, 1'b0);
        send_one(16'h0000, 16'h0000, 1'b0);
        send_one(16'h8000, 16'h8000, 1'b0);

        // backpressure: six beats against a stalled output
        idx = 0; iv = 1'b1; or_v = 1'b0;
        repeat (8) begin
            a_v = 16'h1111 * idx[15:0] + 16'h0F0F; b_v = 16'hF00F ^ idx[15:0]; ci_v = idx[0];
            tick();
            if (acc) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_in_ready", bus.IN_READY, 0);
        or_v = 1'b1; g = 0;
        while ((idx < 6 || q.size() != 0) && g < 50) begin
            iv = idx < 6;
            a_v = 16'h1111 * idx[15:0] + 16'h0F0F; b_v = 16'hF00F ^ idx[15:0]; ci_v = idx[0];
            tick();
            if (acc) idx++;
            g++;
        end
        iv = 1'b0;
        check("bp_total", idx, 6);
        check("bp_drained", q.size(), 0);

        run_beats(100, 100, 100, 1'b1);
        run_beats(1000, 70, 60, 1'b0);

        // reset with three beats in flight
        iv = 1'b1; or_v = 1'b0;
        repeat (3) begin a_v = 16'($urandom); b_v = 16'($urandom); ci_v = 1'b1; tick(); end
        iv = 1'b0;
        check("pre_rst_inflight", q.size(), 3);
        @(posedge clk);
        #2 rstb = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.OUT_VALID, 0);
        check("mid_rst_sum", bus.SUM, 0);
        check("mid_rst_co", bus.CO, 0);
        check("mid_rst_in_ready", bus.IN_READY, 0);
        q.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstb = 1'b1;
        or_v = 1'b1;
        repeat (8) tick();
        check("no_stale_valid", bus.OUT_VALID, 0);
        check("post_rst_in_ready", bus.IN_READY, 1);
        send_one(16'hABCD, 16'h1357, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0 and STAGES >= 1, else elaboration error.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports are named CLK and RSTB.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- RSTB  in  1  async reset, active low.
- IN_VALID  in  1  operand beat present.
- IN_READY  out  1  operand beat accepted this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CI  in  1  carry in.
- OUT_VALID  out  1  result beat present.
- OUT_READY  in  1  downstream accepts result.
- SUM  out  WIDTH  A+B+CI, low WIDTH bits.
- CO  out  1  carry out of the MSB.

Function
REQ-005 SHALL split operands into STAGES slices of W=WIDTH/STAGES bits; stage k adds slice k plus the registered carry from stage k-1; stage 0 uses CI.
REQ-006 SHALL register unconsumed upper operand slices and completed lower sum slices alongside each stage, so each result is bit-exact A+B+CI.
REQ-007 SHALL accept a beat when IN_VALID && IN_READY; results emerge in order, exactly STAGES cycles after acceptance when OUT_READY is held high.
REQ-008 SHALL keep a valid bit per stage; stage k loads iff !valid[k] || ready[k+1]; ready[STAGES] = OUT_READY; IN_READY = ready[0].
REQ-009 SHALL collapse bubbles: an empty stage accepts regardless of downstream stall.
REQ-010 SHALL sustain one beat per cycle with OUT_READY high; with OUT_READY low it holds up to STAGES beats, then IN_READY = 0.
REQ-011 SHALL hold SUM, CO and OUT_VALID stable while OUT_VALID && !OUT_READY.
REQ-012 SHALL accept an input and retire an output in the same cycle when the pipe is full and OUT_READY = 1.
REQ-013 SHALL leave data registers unchanged when their valid bit is 0; stage outputs are don't-care when not valid.
REQ-014 SHALL produce wrap-around results: 0xFFFF + 0x0001 gives SUM = 0x0000, CO = 1 (non-SAT build).

Reset
REQ-015 SHALL clear all valid bits asynchronously on RSTB low; OUT_VALID = 0 and IN_READY = 0 while RSTB = 0.
REQ-016 SHALL drive SUM = 0 and CO = 0 from reset; data registers reset to 0.
REQ-017 SHALL drop in-flight beats on reset mid-operation; IN_READY = 1 on the first clock edge after RSTB rises.

Configuration
REQ-018 SHALL support macro PIPE_ADDER_SAT_EN; when defined, a result with CO = 1 outputs SUM = all ones, and CO still reports 1.
REQ-019 SHALL, without PIPE_ADDER_SAT_EN, output the wrapped SUM; latency and handshake are identical in both builds.

Structure
REQ-020 SHALL place the following in shared package pipe_adder_pkg: parameter-check constants, the slice-width function W = WIDTH/STAGES, and the stage record typedef (valid, carry, partial sum, remaining operands).
REQ-021 SHALL implement one stage as sub-module pipe_adder_stage (W-bit slice add plus valid/ready register), instantiated STAGES times via generate.

Verification
REQ-022 SHALL cover, with WIDTH=16, STAGES=4:
- Reset: RSTB low mid-stream with 3 beats in flight -> OUT_VALID = 0 and SUM = 0; no stale beat after release.
- Single beat: A=0x1234, B=0x0FFF, CI=1, OUT_READY=1 -> SUM=0x2234, CO=0, OUT_VALID exactly 4 cycles after acceptance.
- Carry chain: A=0xFFFF, B=0x0000, CI=1 -> SUM=0x0000, CO=1; with PIPE_ADDER_SAT_EN -> SUM=0xFFFF, CO=1.
- Backpressure: 6 back-to-back beats with OUT_READY=0 -> IN_READY drops after 4 acceptances; releasing OUT_READY drains 4 in order, then accepts the remaining 2.
- Throughput: 100 random beats with IN_VALID and OUT_READY held 1 -> one result per cycle, all match the reference model.
- Random stalls: random IN_VALID/OUT_READY over 1000 beats -> no loss, no duplication, order preserved, SUM/CO stable while stalled.
